// File: rtl/dbg_apb_arb.sv
// Two-requester round-robin arbiter onto one shared APB master port (UART debug bridge + second initiator).
// Optional ACCESS watchdog enabled with macro DBG_APB_ARB_TIMEOUT_EN (limit set by TO_CYC).
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | sample requests, pick winner, latch its payload
// ACCESS | o_penable high, wait for completer i_pready (or watchdog expiry)
// RESP   | one-cycle o_req_pready pulse to the granted requester
module dbg_apb_arb #(
  parameter logic [15:0] TO_CYC = 16'd1023
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [1:0]       i_req_penable,
  input  logic [1:0]       i_req_pwrite,
  input  logic [1:0][31:0] i_req_paddr,
  input  logic [1:0][31:0] i_req_pwdata,
  output logic [1:0]       o_req_pready,
  output logic [31:0]      o_req_prdata,
  output logic             o_penable,
  output logic             o_pwrite,
  output logic [31:0]      o_paddr,
  output logic [31:0]      o_pwdata,
  input  logic             i_pready,
  input  logic [31:0]      i_prdata,
  output logic             o_timeout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        grant;
  logic        last_grant;
  logic        winner;
  logic        cap_en;
  logic [31:0] cap_data;
  logic        to_hit;

  // Contention goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    winner = 1'b0;
    case (i_req_penable)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant;
      default: winner = 1'b0;
    endcase
  end

`ifdef DBG_APB_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        to_flag;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      to_cnt <= 16'd0;
    end else if (state == IDLE) begin
      to_cnt <= TO_CYC - 16'd1;
    end else if (state == ACCESS && to_cnt != 16'd0) begin
      to_cnt <= to_cnt - 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      to_flag <= 1'b0;
    end else if (cap_en) begin
      to_flag <= to_hit;
    end
  end

  assign o_timeout = (state == RESP) && to_flag;
`else
  logic unused_to_cyc;
  assign unused_to_cyc = ^TO_CYC;
  assign o_timeout     = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cap_en    = 1'b0;
    cap_data  = i_prdata;
    to_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (|i_req_penable) state_nxt = ACCESS;
      end
      ACCESS: begin
        // A completer ready in the expiry cycle still counts as a normal completion.
        if (i_pready) begin
          cap_en    = 1'b1;
          state_nxt = RESP;
        end
`ifdef DBG_APB_ARB_TIMEOUT_EN
        else if (to_cnt == 16'd0) begin
          cap_en    = 1'b1;
          cap_data  = 32'hDEAD_DEAD;
          to_hit    = 1'b1;
          state_nxt = RESP;
        end
`endif
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      o_pwrite   <= 1'b0;
      o_paddr    <= 32'd0;
      o_pwdata   <= 32'd0;
    end else if (state == IDLE && |i_req_penable) begin
      grant      <= winner;
      last_grant <= winner;
      o_pwrite   <= i_req_pwrite[winner];
      o_paddr    <= i_req_paddr[winner];
      o_pwdata   <= i_req_pwdata[winner];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_req_prdata <= 32'd0;
    end else if (cap_en) begin
      o_req_prdata <= cap_data;
    end
  end

  assign o_penable    = (state == ACCESS);
  assign o_req_pready = (state != RESP) ? 2'b00 : (grant ? 2'b10 : 2'b01);

endmodule
